switch_output_arbiter: RTL and testbench

//   Per-output-port scheduler for the 4-port network switch. Watches all input ports,

---
 rtl/switch_output_arbiter.sv | 132 +++++++++++++
 tb/tb_switch_output_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_output_arbiter.sv
// Per-output-port scheduler: queues packets addressed to PORT_ID in per-input FIFOs and
// round-robins FIFO heads onto the output. Define SWITCH_ARB_DROP_CNT_EN for drop counters.
module switch_output_arbiter #(
   parameter int unsigned NUM_PORTS  = 4,
   parameter int unsigned PORT_ID    = 0,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_PORTS-1:0]       valid_in,
   input  logic [4*NUM_PORTS-1:0]     source_in,
   input  logic [4*NUM_PORTS-1:0]     target_in,
   input  logic [8*NUM_PORTS-1:0]     data_in,
   output logic                       valid_out,
   output logic [3:0]                 source_out,
   output logic [3:0]                 target_out,
   output logic [7:0]                 data_out,
`ifdef SWITCH_ARB_DROP_CNT_EN
   output logic [CNT_W*NUM_PORTS-1:0] drop_cnt,
`endif
   output logic [NUM_PORTS-1:0]       fifo_full
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_FW = PTR_W + 1;
   localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [NUM_PORTS-1:0]    push_req;
   logic [NUM_PORTS-1:0]    non_empty;
   logic [NUM_PORTS-1:0]    full;
   logic [NUM_PORTS-1:0]    pop;
   logic [16*NUM_PORTS-1:0] head_flat;

   logic                    grant_valid;
   logic [IDX_W-1:0]        grant_idx;
   logic [IDX_W-1:0]        cand;
   logic [15:0]             grant_head;
   logic [IDX_W-1:0]        last_grant_q;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
      logic [15:0]       mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0]  wr_ptr_q;
      logic [PTR_W-1:0]  rd_ptr_q;
      logic [CNT_FW-1:0] count_q;
      logic              accept;

      // Only this output's bit of the mask matters; other bits belong to other instances.
      assign push_req[i] = valid_in[i] & target_in[4*i+PORT_ID];
      assign non_empty[i] = (count_q != '0);
      assign full[i] = (count_q == CNT_FW'(FIFO_DEPTH));
      // A full FIFO still takes a push when its head leaves on the same edge.
      assign accept = push_req[i] & (~full[i] | pop[i]);
      assign head_flat[16*i +: 16] = mem_q[rd_ptr_q];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop[i]) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_FW'(accept) - CNT_FW'(pop[i]);
         end
      end

      always_ff @(posedge clk) begin
         if (accept) begin
            mem_q[wr_ptr_q] <= {source_in[4*i +: 4], target_in[4*i +: 4], data_in[8*i +: 8]};
         end
      end

`ifdef SWITCH_ARB_DROP_CNT_EN
      logic [CNT_W-1:0] drop_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            drop_q <= '0;
         end else if (push_req[i] && full[i] && !pop[i] && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
         end
      end

      assign drop_cnt[CNT_W*i +: CNT_W] = drop_q;
`endif
   end

   // Round-robin search starting just after the last winner.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = last_grant_q;
      cand        = '0;
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
         cand = IDX_W'((32'(last_grant_q) + k) % NUM_PORTS);
         if (!grant_valid && non_empty[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      pop        = '0;
      grant_head = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (grant_valid && (grant_idx == IDX_W'(i))) begin
            pop[i]     = 1'b1;
            grant_head = head_flat[16*i +: 16];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out    <= 1'b0;
         source_out   <= '0;
         target_out   <= '0;
         data_out     <= '0;
         last_grant_q <= IDX_W'(NUM_PORTS - 1);
      end else begin
         valid_out <= grant_valid;
         if (grant_valid) begin
            last_grant_q                       <= grant_idx;
            {source_out, target_out, data_out} <= grant_head;
         end
      end
   end

   assign fifo_full = full;

endmodule

// File: tb/tb_switch_output_arbiter.sv
// Directed testbench for switch_output_arbiter serving output port 2.
// Drop-counter checks are active when SWITCH_ARB_DROP_CNT_EN is defined.
module tb_switch_output_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  valid_in = '0;
   logic [15:0] source_in = '0;
   logic [15:0] target_in = '0;
   logic [31:0] data_in = '0;
   logic        valid_out;
   logic [3:0]  source_out;
   logic [3:0]  target_out;
   logic [7:0]  data_out;
   logic [3:0]  fifo_full;
`ifdef SWITCH_ARB_DROP_CNT_EN
   logic [31:0] drop_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Hand-derived grant order for the overflow scenario, one entry per edge E1..E14.
   localparam logic [7:0] EXP_SEQ [14] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21,
                                          8'h31, 8'h02, 8'h12, 8'h22, 8'h32, 8'h33, 8'h34};

   switch_output_arbiter #(
      .NUM_PORTS (4),
      .PORT_ID   (2),
      .FIFO_DEPTH(4),
      .CNT_W     (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .source_in (source_in),
      .target_in (target_in),
      .data_in   (data_in),
      .valid_out (valid_out),
      .source_out(source_out),
      .target_out(target_out),
      .data_out  (data_out),
`ifdef SWITCH_ARB_DROP_CNT_EN
      .drop_cnt  (drop_cnt),
`endif
      .fifo_full (fifo_full)
   );

   always #5 clk = ~clk;

   task automatic tick(input logic [3:0] v, input logic [15:0] src, input logic [15:0] tgt,
                       input logic [31:0] dat);
      valid_in  = v;
      source_in = src;
      target_in = tgt;
      data_in   = dat;
      @(posedge clk);
      #1;
      valid_in  = '0;
      source_in = '0;
      target_in = '0;
      data_in   = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      vectors++;
      if ({valid_out, source_out, target_out, data_out, fifo_full} !== 21'h0) begin
         $display("FAIL reset_outputs: got v=%b s=%h t=%h d=%h full=%b, want all 0",
                  valid_out, source_out, target_out, data_out, fifo_full);
         miscompares++;
      end
`ifdef SWITCH_ARB_DROP_CNT_EN
      vectors++;
      if (drop_cnt !== 32'h0) begin
         $display("FAIL reset_drop_cnt: got %h want 0", drop_cnt);
         miscompares++;
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_push();
      do_reset();
      tick(4'b0010, 16'h0010, 16'h0040, 32'h0000_A500);
      vectors++;
      if (valid_out !== 1'b0) begin
         $display("FAIL single_no_bypass: valid_out got %b want 0", valid_out);
         miscompares++;
      end
      tick('0, '0, '0, '0);
      vectors++;
      if ({valid_out, source_out, target_out, data_out} !== {1'b1, 4'd1, 4'b0100, 8'hA5}) begin
         $display("FAIL single_grant: got v=%b s=%h t=%b d=%h want v=1 s=1 t=0100 d=a5",
                  valid_out, source_out, target_out, data_out);
         miscompares++;
      end
      tick('0, '0, '0, '0);
      vectors++;
      if ({valid_out, data_out} !== {1'b0, 8'hA5}) begin
         $display("FAIL single_idle_hold: got v=%b d=%h want v=0 d=a5", valid_out, data_out);
         miscompares++;
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      tick(4'hF, 16'h3210, 16'h4444, 32'h1312_1110);
      for (int k = 0; k < 4; k++) begin
         tick('0, '0, '0, '0);
         vectors++;
         if ({valid_out, source_out, data_out} !== {1'b1, 4'(k), 8'(8'h10 + k)}) begin
            $display("FAIL rr_grant_%0d: got v=%b s=%h d=%h want v=1 s=%0d d=%h", k,
                     valid_out, source_out, data_out, k, 8'(8'h10 + k));
            miscompares++;
         end
      end
      tick('0, '0, '0, '0);
      vectors++;
      if (valid_out !== 1'b0) begin
         $display("FAIL rr_drained: valid_out got %b want 0", valid_out);
         miscompares++;
      end
      // last winner was 3, so input 0 must beat input 3 on a tie
      tick(4'b1001, 16'h3000, 16'h4004, 32'h2300_0020);
      tick('0, '0, '0, '0);
      vectors++;
      if ({valid_out, source_out, data_out} !== {1'b1, 4'd0, 8'h20}) begin
         $display("FAIL rr_wrap_first: got v=%b s=%h d=%h want v=1 s=0 d=20",
                  valid_out, source_out, data_out);
         miscompares++;
      end
      tick('0, '0, '0, '0);
      vectors++;
      if ({valid_out, source_out, data_out} !== {1'b1, 4'd3, 8'h23}) begin
         $display("FAIL rr_wrap_second: got v=%b s=%h d=%h want v=1 s=3 d=23",
                  valid_out, source_out, data_out);
         miscompares++;
      end
   endtask

   task automatic test_ignored_target();
      do_reset();
      tick(4'b0011, 16'h0010, 16'h002B, 32'h0000_6655);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if ({valid_out, fifo_full} !== 5'b0) begin
            $display("FAIL ignored_target_%0d: got v=%b full=%b want v=0 full=0000", k,
                     valid_out, fifo_full);
            miscompares++;
         end
`ifdef SWITCH_ARB_DROP_CNT_EN
         vectors++;
         if (drop_cnt !== 32'h0) begin
            $display("FAIL ignored_drop_%0d: got %h want 0", k, drop_cnt);
            miscompares++;
         end
`endif
         tick('0, '0, '0, '0);
      end
   endtask

   task automatic test_overflow();
      logic [3:0]  v;
      logic [31:0] dat;
      logic [3:0]  exp_full;
      do_reset();
      for (int j = 0; j <= 15; j++) begin
         v   = (j < 3) ? 4'hF : ((j < 6) ? 4'b1000 : 4'b0000);
         dat = {8'(48 + j), 8'(32 + j), 8'(16 + j), 8'(j)};
         if (v != 4'b0000) tick(v, 16'h3210, 16'h4444, dat);
         else tick('0, '0, '0, '0);
         vectors++;
         if (j == 0 || j == 15) begin
            if (valid_out !== 1'b0) begin
               $display("FAIL ovf_idle_e%0d: valid_out got %b want 0", j, valid_out);
               miscompares++;
            end
         end else if ({valid_out, source_out, target_out, data_out} !==
                      {1'b1, EXP_SEQ[j-1][7:4], 4'b0100, EXP_SEQ[j-1]}) begin
            $display("FAIL ovf_order_e%0d: got v=%b s=%h t=%b d=%h want v=1 s=%h t=0100 d=%h",
                     j, valid_out, source_out, target_out, data_out, EXP_SEQ[j-1][7:4],
                     EXP_SEQ[j-1]);
            miscompares++;
         end
         exp_full = (j >= 3 && j <= 7) ? 4'b1000 : 4'b0000;
         vectors++;
         if (fifo_full !== exp_full) begin
            $display("FAIL ovf_full_e%0d: got %b want %b", j, fifo_full, exp_full);
            miscompares++;
         end
`ifdef SWITCH_ARB_DROP_CNT_EN
         vectors++;
         if (drop_cnt !== {8'((j >= 5) ? 1 : 0), 24'h0}) begin
            $display("FAIL ovf_drop_e%0d: got %h want %h", j, drop_cnt,
                     {8'((j >= 5) ? 1 : 0), 24'h0});
            miscompares++;
         end
`endif
      end
   endtask

   task automatic test_reset_midcycle();
      do_reset();
      tick(4'b0111, 16'h0210, 16'h0444, 32'h0042_4140);
      tick('0, '0, '0, '0);
      vectors++;
      if ({valid_out, data_out} !== {1'b1, 8'h40}) begin
         $display("FAIL midrst_pre: got v=%b d=%h want v=1 d=40", valid_out, data_out);
         miscompares++;
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({valid_out, source_out, target_out, data_out, fifo_full} !== 21'h0) begin
         $display("FAIL midrst_async: got v=%b s=%h t=%h d=%h full=%b want all 0",
                  valid_out, source_out, target_out, data_out, fifo_full);
         miscompares++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick('0, '0, '0, '0);
         vectors++;
         if (valid_out !== 1'b0) begin
            $display("FAIL midrst_flushed_%0d: valid_out got %b want 0", k, valid_out);
            miscompares++;
         end
      end
      tick(4'b1010, 16'h3010, 16'h4040, 32'h5300_5100);
      tick('0, '0, '0, '0);
      vectors++;
      if ({valid_out, source_out, data_out} !== {1'b1, 4'd1, 8'h51}) begin
         $display("FAIL midrst_first: got v=%b s=%h d=%h want v=1 s=1 d=51",
                  valid_out, source_out, data_out);
         miscompares++;
      end
      tick('0, '0, '0, '0);
      vectors++;
      if ({valid_out, source_out, data_out} !== {1'b1, 4'd3, 8'h53}) begin
         $display("FAIL midrst_second: got v=%b s=%h d=%h want v=1 s=3 d=53",
                  valid_out, source_out, data_out);
         miscompares++;
      end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_round_robin();
      test_ignored_target();
      test_overflow();
      test_reset_midcycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
